mem_rr_scheduler: RTL
=====================

Name: mem_rr_scheduler

Overview:
- Four-port round-robin scheduler in front of one single-port synchronous SRAM. The SRAM has 1-cycle read latency.
- Replaces fixed-priority sharing with fair rotation.
- Supports requester-held burst locks.
- Routes registered read data back to the issuing port with a per-port valid strobe.
- Sits between the baseband engines (correlator state, TE FIFO, AE buffer, host access) and a shared buffer RAM.

Parameters:
- ADDR_WIDTH, 10, SRAM address width.
- DATA_WIDTH, 32, SRAM data width.
- MAX_BURST, 4, maximum consecutive grants one port may hold under lock; legal range 1..16.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_b  input  1  asynchronous active-low reset.
- mem_rdN_i  input  1  read request, port N (N=0..3).
- mem_wrN_i  input  1  write request, port N.
- mem_lockN_i  input  1  burst lock, port N; qualifies rd/wr.
- mem_addrN_i  input  ADDR_WIDTH  address, port N.
- mem_d4wtN_i  input  DATA_WIDTH  write data, port N.
- mem_acceptN_o  output  1  request of port N taken this cycle.
- mem_rdvalidN_o  output  1  read data for port N valid this cycle.
- mem_d4rdN_o  output  DATA_WIDTH  read data, port N; 0 when rdvalid low.
- mem_rd_o  output  1  SRAM read enable.
- mem_wr_o  output  1  SRAM write enable.
- mem_addr_o  output  ADDR_WIDTH  SRAM address.
- mem_d4wt_o  output  DATA_WIDTH  SRAM write data.
- mem_d4rd_i  input  DATA_WIDTH  SRAM read data; valid the cycle after mem_rd_o.

Behaviour:
- State registers:
  - rr_ptr[1:0]: current highest-priority port.
  - burst_cnt[3:0].
  - rd_pend[3:0]: one-hot read-return tag.
- Reset values: rr_ptr=0, burst_cnt=0, rd_pend=0. All registered outputs are 0. All combinational outputs are 0 while no request is present.
- req[N] = mem_rdN_i | mem_wrN_i. Requests are level-held by the requester until accepted.
- Grant is combinational, same cycle. The winner is the first port with req set, searching rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 mod 4. At most one accept per cycle.
- The winner drives mem_addr_o.
- If the winner's wr is set: mem_wr_o=1, mem_rd_o=0, mem_d4wt_o = its data. Write has precedence when rd and wr are both set on one port. That read is not performed; the requester keeps rd asserted and it is served on a later grant.
- Otherwise: mem_rd_o=1 and mem_d4wt_o=0.
- No request: mem_rd_o=0, mem_wr_o=0, mem_addr_o=0, mem_d4wt_o=0.
- Pointer update on a grant to port k:
  - If mem_lockk_i=1 and burst_cnt < MAX_BURST-1: rr_ptr stays k and burst_cnt increments.
  - Otherwise: rr_ptr <= (k+1) mod 4 and burst_cnt <= 0.
- With MAX_BURST=1, lock has no effect.
- A cycle with no grant leaves rr_ptr unchanged and clears burst_cnt.
- While locked, the locking port wins whenever it requests. If it drops its request, another port wins by normal search from rr_ptr. That grant applies the update rule for its own port, which ends the burst.
- Read return:
  - rd_pend <= one-hot of the read winner, or 0 for a write or no grant.
  - mem_rdvalidN_o = rd_pend[N].
  - mem_d4rdN_o = rd_pend[N] ? mem_d4rd_i : 0.
  - Read latency from accept to rdvalid is exactly 1 cycle.
  - Back-to-back reads from different ports return in grant order, one per cycle.
- Reset asserted mid-operation: state clears asynchronously. A pending rdvalid is dropped, with no strobe after reset release. Requesters must re-issue.
- The address width is not checked; requesters own address range.

Test Plan:
- Reset, then all four ports assert rd continuously, no lock → accepts in order 0,1,2,3,0,… one per cycle. rdvalid0 occurs 1 cycle after accept0 with mem_d4rd0_o equal to SRAM content, and mem_d4rd1..3_o=0 in that cycle.
- rr_ptr=2 (after a grant to port 1); ports 0 and 3 request → port 3 wins, then port 0.
- MAX_BURST=4; port 1 writes with lock held for 6 cycles while port 2 requests → accept1 for 4 cycles, then accept2, then accept1 resumes. Written data at addrs A..A+3 reads back correctly.
- Port 0 asserts rd and wr together at addr 0x05 with data 0xDEADBEEF → mem_wr_o=1, mem_rd_o=0, no rdvalid0 next cycle. Port 0 holds rd; the subsequent grant returns 0xDEADBEEF.
- Port 2 read accepted, rst_b pulsed low before the next edge → mem_rdvalid2_o stays 0, and rr_ptr=0 after release (port 0 wins a 0/3 contention).
- Idle cycles between grants → rr_ptr held and burst_cnt cleared. A lock burst interrupted by an idle cycle restarts counting at 0.

Source files
------------

// File: rtl/mem_rr_scheduler.sv
// Four-port round-robin arbiter with burst lock in front of a single-port SRAM.
// Latency: grant/SRAM command same cycle (combinational); read data 1 cycle after accept.
// Backpressure: requesters hold rd/wr level until their accept strobe; one accept per cycle.
module mem_rr_scheduler #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  mem_rd0_i,
  input  logic                  mem_rd1_i,
  input  logic                  mem_rd2_i,
  input  logic                  mem_rd3_i,
  input  logic                  mem_wr0_i,
  input  logic                  mem_wr1_i,
  input  logic                  mem_wr2_i,
  input  logic                  mem_wr3_i,
  input  logic                  mem_lock0_i,
  input  logic                  mem_lock1_i,
  input  logic                  mem_lock2_i,
  input  logic                  mem_lock3_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr0_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr1_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr2_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr3_i,
  input  logic [DATA_WIDTH-1:0] mem_d4wt0_i,
  input  logic [DATA_WIDTH-1:0] mem_d4wt1_i,
  input  logic [DATA_WIDTH-1:0] mem_d4wt2_i,
  input  logic [DATA_WIDTH-1:0] mem_d4wt3_i,
  output logic                  mem_accept0_o,
  output logic                  mem_accept1_o,
  output logic                  mem_accept2_o,
  output logic                  mem_accept3_o,
  output logic                  mem_rdvalid0_o,
  output logic                  mem_rdvalid1_o,
  output logic                  mem_rdvalid2_o,
  output logic                  mem_rdvalid3_o,
  output logic [DATA_WIDTH-1:0] mem_d4rd0_o,
  output logic [DATA_WIDTH-1:0] mem_d4rd1_o,
  output logic [DATA_WIDTH-1:0] mem_d4rd2_o,
  output logic [DATA_WIDTH-1:0] mem_d4rd3_o,
  output logic                  mem_rd_o,
  output logic                  mem_wr_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_d4wt_o,
  input  logic [DATA_WIDTH-1:0] mem_d4rd_i
);

  // Last burst count value at which a locked port may still keep the pointer.
  localparam logic [3:0] LP_BURST_LAST = 4'(MAX_BURST - 1);

  logic [1:0] r_rr_ptr;
  logic [3:0] r_burst_cnt;
  logic [3:0] r_rd_pend;

  logic [3:0]            w_rd;
  logic [3:0]            w_wr;
  logic [3:0]            w_lock;
  logic [3:0]            w_req;
  logic [ADDR_WIDTH-1:0] w_addr [4];
  logic [DATA_WIDTH-1:0] w_wdat [4];
  logic                  w_gnt_vld;
  logic [1:0]            w_gnt_idx;
  logic [3:0]            w_gnt_oh;
  logic                  w_gnt_wr;
  logic                  w_gnt_rd;

  assign w_rd   = {mem_rd3_i, mem_rd2_i, mem_rd1_i, mem_rd0_i};
  assign w_wr   = {mem_wr3_i, mem_wr2_i, mem_wr1_i, mem_wr0_i};
  assign w_lock = {mem_lock3_i, mem_lock2_i, mem_lock1_i, mem_lock0_i};
  assign w_req  = w_rd | w_wr;

  assign w_addr[0] = mem_addr0_i;
  assign w_addr[1] = mem_addr1_i;
  assign w_addr[2] = mem_addr2_i;
  assign w_addr[3] = mem_addr3_i;
  assign w_wdat[0] = mem_d4wt0_i;
  assign w_wdat[1] = mem_d4wt1_i;
  assign w_wdat[2] = mem_d4wt2_i;
  assign w_wdat[3] = mem_d4wt3_i;

  // Rotating search from r_rr_ptr; scanning farthest-first lets the nearest requester win.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = r_rr_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (w_req[r_rr_ptr + 2'(i)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = r_rr_ptr + 2'(i);
      end
    end
  end

  // Write wins over read on the same port; the read stays pending at the requester.
  assign w_gnt_oh = w_gnt_vld ? (4'b0001 << w_gnt_idx) : 4'b0000;
  assign w_gnt_wr = w_gnt_vld & w_wr[w_gnt_idx];
  assign w_gnt_rd = w_gnt_vld & ~w_wr[w_gnt_idx];

  assign mem_accept0_o = w_gnt_oh[0];
  assign mem_accept1_o = w_gnt_oh[1];
  assign mem_accept2_o = w_gnt_oh[2];
  assign mem_accept3_o = w_gnt_oh[3];

  assign mem_wr_o   = w_gnt_wr;
  assign mem_rd_o   = w_gnt_rd;
  assign mem_addr_o = w_gnt_vld ? w_addr[w_gnt_idx] : '0;
  assign mem_d4wt_o = w_gnt_wr ? w_wdat[w_gnt_idx] : '0;

  // Pointer/burst update and read-return tag capture.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_rr_ptr    <= 2'd0;
      r_burst_cnt <= 4'd0;
      r_rd_pend   <= 4'd0;
    end else begin
      r_rd_pend <= w_gnt_rd ? w_gnt_oh : 4'd0;
      if (!w_gnt_vld) begin
        r_burst_cnt <= 4'd0;
      end else if (w_lock[w_gnt_idx] && (r_burst_cnt < LP_BURST_LAST)) begin
        r_rr_ptr    <= w_gnt_idx;
        r_burst_cnt <= r_burst_cnt + 4'd1;
      end else begin
        r_rr_ptr    <= w_gnt_idx + 2'd1;
        r_burst_cnt <= 4'd0;
      end
    end
  end

  assign mem_rdvalid0_o = r_rd_pend[0];
  assign mem_rdvalid1_o = r_rd_pend[1];
  assign mem_rdvalid2_o = r_rd_pend[2];
  assign mem_rdvalid3_o = r_rd_pend[3];

  assign mem_d4rd0_o = r_rd_pend[0] ? mem_d4rd_i : '0;
  assign mem_d4rd1_o = r_rd_pend[1] ? mem_d4rd_i : '0;
  assign mem_d4rd2_o = r_rd_pend[2] ? mem_d4rd_i : '0;
  assign mem_d4rd3_o = r_rd_pend[3] ? mem_d4rd_i : '0;

endmodule
